// File: rtl/tdm_demux4.sv
// Receive-side 1:4 TDM demultiplexer: frame_sync marks slot 0, words fan out to A..D.
// Optional FRAME_LATCH_EN: slots collect in shadow registers and A..D update together per frame.
module tdm_demux4 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] C,
  output logic [DATA_W-1:0] D,
  output logic [3:0]        ch_valid,
  output logic              frame_done,
  output logic              locked,
  output logic              sync_err
);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [1:0]        slot_q, slot_d;
  logic              frame_ok_q, frame_ok_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [3:0]        ch_valid_q, ch_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              locked_q, locked_d;
  logic              sync_err_q, sync_err_d;
  logic              take;
  logic [1:0]        wslot;

`ifdef FRAME_LATCH_EN
  logic [DATA_W-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
`endif

  // Framing decision: which slot (if any) this word lands in, and the next FSM state.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    frame_ok_d   = frame_ok_q;
    sync_err_d   = 1'b0;
    take         = 1'b0;
    wslot        = slot_q;
    if (din_valid) begin
      if (state_q == HUNT) begin
        if (frame_sync) begin
          take       = 1'b1;
          wslot      = 2'd0;
          slot_d     = 2'd1;
          state_d    = LOCK;
          frame_ok_d = 1'b1;
        end
      end else if (frame_sync) begin
        // Sync always restarts the frame; a sync off slot 0 taints the new frame too.
        take       = 1'b1;
        wslot      = 2'd0;
        slot_d     = 2'd1;
        frame_ok_d = (slot_q == 2'd0);
        sync_err_d = (slot_q != 2'd0);
      end else if (slot_q == 2'd0) begin
        sync_err_d = 1'b1;
        state_d    = HUNT;
        slot_d     = 2'd0;
        frame_ok_d = 1'b0;
      end else begin
        take   = 1'b1;
        wslot  = slot_q;
        slot_d = slot_q + 2'd1;
      end
    end
    locked_d = (state_d == LOCK);
  end

  // Channel data and strobes.
  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    d_d          = d_q;
    ch_valid_d   = 4'b0000;
    frame_done_d = 1'b0;
`ifdef FRAME_LATCH_EN
    sh0_d = sh0_q;
    sh1_d = sh1_q;
    sh2_d = sh2_q;
    if (take) begin
      case (wslot)
        2'd0: sh0_d = din;
        2'd1: sh1_d = din;
        2'd2: sh2_d = din;
        default: begin
          a_d          = sh0_q;
          b_d          = sh1_q;
          c_d          = sh2_q;
          d_d          = din;
          ch_valid_d   = 4'b1111;
          frame_done_d = 1'b1;
        end
      endcase
    end
`else
    if (take) begin
      ch_valid_d = 4'b0001 << wslot;
      case (wslot)
        2'd0: a_d = din;
        2'd1: b_d = din;
        2'd2: c_d = din;
        default: begin
          d_d          = din;
          frame_done_d = frame_ok_q;
        end
      endcase
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      slot_q       <= 2'd0;
      frame_ok_q   <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      d_q          <= '0;
      ch_valid_q   <= 4'b0000;
      frame_done_q <= 1'b0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
`ifdef FRAME_LATCH_EN
      sh0_q        <= '0;
      sh1_q        <= '0;
      sh2_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      frame_ok_q   <= frame_ok_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      d_q          <= d_d;
      ch_valid_q   <= ch_valid_d;
      frame_done_q <= frame_done_d;
      locked_q     <= locked_d;
      sync_err_q   <= sync_err_d;
`ifdef FRAME_LATCH_EN
      sh0_q        <= sh0_d;
      sh1_q        <= sh1_d;
      sh2_q        <= sh2_d;
`endif
    end
  end

  assign A          = a_q;
  assign B          = b_q;
  assign C          = c_q;
  assign D          = d_q;
  assign ch_valid   = ch_valid_q;
  assign frame_done = frame_done_q;
  assign locked     = locked_q;
  assign sync_err   = sync_err_q;

endmodule
